hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have idex_MemRead, idex_RegWrite, input, 1 bit each: control fields read back from the ID/EX register outputs.
REQ-004 SHALL have idex_rs1, idex_rs2, idex_rd, input, 5 bits each: register indices from the ID/EX register outputs.
REQ-005 SHALL have ifid_rs1, ifid_rs2, input, 5 bits each, and ifid_uses_rs2, input, 1 bit: operands of the instruction in decode.
REQ-006 SHALL have exmem_RegWrite, memwb_RegWrite, input, 1 bit each, and exmem_rd, memwb_rd, input, 5 bits each.
REQ-007 SHALL have branch_taken, input, 1 bit (resolved in EX), and mem_busy, input, 1 bit (data memory not ready).
REQ-008 SHALL have pc_write, ifid_write, idex_write, output, 1 bit each: enables for the PC and pipeline registers.
REQ-009 SHALL have idex_bubble, output, 1 bit: zero all control inputs of ID/EX this cycle.
REQ-010 SHALL have ifid_flush, output, 1 bit: load a NOP into IF/ID.
REQ-011 SHALL have forward_a, forward_b, output, 2 bits each: ALU operand source select.
REQ-012 SHALL have stall_cnt, flush_cnt, output, 16 bits each: performance counters.

Function
REQ-013 SHALL implement FSM states RUN and MEM_WAIT.
REQ-014 In RUN, mem_busy=1 SHALL force pc_write=ifid_write=idex_write=0, idex_bubble=0, ifid_flush=0 in the same cycle, and SHALL move to MEM_WAIT.
REQ-015 In MEM_WAIT, all write enables SHALL stay 0 while mem_busy=1; mem_busy=0 SHALL return the FSM to RUN with normal evaluation in that same cycle.
REQ-016 In RUN with mem_busy=0, branch_taken=1 SHALL assert ifid_flush=1 and idex_bubble=1, with pc_write=ifid_write=idex_write=1.
REQ-017 In RUN with mem_busy=0 and branch_taken=0, a load-use hazard SHALL assert pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1.
REQ-018 A load-use hazard SHALL be defined as idex_MemRead=1, idex_rd!=0, and idex_rd equal to ifid_rs1 or (ifid_uses_rs2 and ifid_rs2).
REQ-019 Event priority SHALL be mem_busy > branch_taken > load-use. A branch SHALL discard a simultaneous load-use stall.
REQ-020 forward_a SHALL be combinational: FWD_EXMEM (10) if exmem_RegWrite=1, exmem_rd!=0 and exmem_rd==idex_rs1; otherwise FWD_MEMWB (01) if the same condition holds for memwb; otherwise FWD_REG (00). forward_b SHALL follow the same rule using idex_rs2.
REQ-021 EX/MEM forwarding SHALL win when both stages match. Register x0 SHALL never be forwarded.
REQ-022 stall_cnt SHALL increment by 1 on every clock edge where pc_write=0, and SHALL saturate at 16'hFFFF.
REQ-023 flush_cnt SHALL increment by 1 on every clock edge where ifid_flush=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-024 With rst_n=0 at a clock edge: state SHALL become RUN and stall_cnt=flush_cnt=0.
REQ-025 While rst_n=0: pc_write=ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=0, forward_a=forward_b=00.
REQ-026 Reset asserted during MEM_WAIT SHALL abandon the wait unconditionally.

Structure
REQ-027 Package hazard_pkg SHALL hold the state enum, the forward-select enum (FWD_REG, FWD_MEMWB, FWD_EXMEM) and the counter width constant CNT_W=16.
REQ-028 Sub-module forward_unit (purely combinational, instanced once) SHALL produce forward_a and forward_b. The FSM and counters SHALL live in hazard_unit.

Verification
REQ-029 The bench SHALL cover load-use: idex_MemRead=1, idex_rd=5, ifid_rs1=5 -> one cycle with pc_write=0 and idex_bubble=1, stall_cnt 0->1; next cycle with idex_MemRead=0 -> pc_write=1.
REQ-030 The bench SHALL cover double forwarding: exmem_rd=memwb_rd=idex_rs1=7, both RegWrite=1 -> forward_a=10; exmem_RegWrite=0 -> forward_a=01; idex_rs1=0 -> 00.
REQ-031 The bench SHALL cover memory wait: mem_busy=1 for 3 cycles -> all enables 0 for 3 cycles, stall_cnt=3, FSM back in RUN when mem_busy=0.
REQ-032 The bench SHALL cover branch plus hazard: branch_taken=1 together with a load-use hazard -> ifid_flush=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
REQ-033 The bench SHALL cover saturation: preload 16'hFFFE stalls, then 3 more stall cycles -> stall_cnt=16'hFFFF.
REQ-034 The bench SHALL cover reset mid-wait: rst_n=0 during MEM_WAIT with mem_busy=1 -> next cycle state RUN and counters 0; after release with mem_busy=0 -> pc_write=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
package hazard_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned REG_W = 5;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_e;

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/hazard_unit_forward.sv
// Combinational ALU operand forwarding select; EX/MEM beats MEM/WB, x0 never forwarded.
module forward_unit
    import hazard_pkg::*;
(
    input  logic             exmem_regwrite_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic             memwb_regwrite_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic [REG_W-1:0] idex_rs1_i,
    input  logic [REG_W-1:0] idex_rs2_i,
    output logic [1:0]       forward_a_o,
    output logic [1:0]       forward_b_o
);

    function automatic fwd_e fwd_sel(
        input logic             ex_we,
        input logic [REG_W-1:0] ex_rd,
        input logic             wb_we,
        input logic [REG_W-1:0] wb_rd,
        input logic [REG_W-1:0] rs
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == rs)) begin
            return FWD_EXMEM;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            return FWD_MEMWB;
        end
        return FWD_REG;
    endfunction

    always_comb begin
        forward_a_o = fwd_sel(exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i, idex_rs1_i);
        forward_b_o = fwd_sel(exmem_regwrite_i, exmem_rd_i, memwb_regwrite_i, memwb_rd_i, idex_rs2_i);
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: memory-wait FSM, branch flush, load-use stall,
// forwarding selects and saturating stall/flush performance counters.
module hazard_unit
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_MemRead,
    input  logic             idex_RegWrite,
    input  logic [REG_W-1:0] idex_rs1,
    input  logic [REG_W-1:0] idex_rs2,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic             exmem_RegWrite,
    input  logic             memwb_RegWrite,
    input  logic [REG_W-1:0] exmem_rd,
    input  logic [REG_W-1:0] memwb_rd,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             load_use;
    logic [1:0]       fwd_a_c, fwd_b_c;
    logic             unused_inputs;

    // The ID/EX RegWrite field has no bearing on any hazard decision here.
    assign unused_inputs = idex_RegWrite;

    forward_unit u_forward (
        .exmem_regwrite_i (exmem_RegWrite),
        .exmem_rd_i       (exmem_rd),
        .memwb_regwrite_i (memwb_RegWrite),
        .memwb_rd_i       (memwb_rd),
        .idex_rs1_i       (idex_rs1),
        .idex_rs2_i       (idex_rs2),
        .forward_a_o      (fwd_a_c),
        .forward_b_o      (fwd_b_c)
    );

    assign load_use = idex_MemRead && (idex_rd != '0) &&
                      ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;

        case (state_q)
            ST_RUN:      if (mem_busy)  state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: if (!mem_busy) state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase

        // Leaving MEM_WAIT evaluates exactly like RUN, so outputs depend only on inputs.
        if (!rst_n) begin
            state_d     = ST_RUN;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = pc_write   ? stall_cnt_q : sat_inc(stall_cnt_q);
        flush_cnt_d = ifid_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign forward_a = rst_n ? fwd_a_c : 2'(FWD_REG);
    assign forward_b = rst_n ? fwd_b_c : 2'(FWD_REG);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed and randomized checks of hazard_unit against a rule-level reference model.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idex_MemRead, idex_RegWrite;
    logic [4:0] idex_rs1, idex_rs2, idex_rd;
    logic [4:0] ifid_rs1, ifid_rs2;
    logic       ifid_uses_rs2;
    logic       exmem_RegWrite, memwb_RegWrite;
    logic [4:0] exmem_rd, memwb_rd;
    logic       branch_taken, mem_busy;
    logic       pc_write, ifid_write, idex_write, idex_bubble, ifid_flush;
    logic [1:0] forward_a, forward_b;
    logic [15:0] stall_cnt, flush_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_stall = 0;
    int m_flush = 0;
    bit m_wait  = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .idex_MemRead(idex_MemRead), .idex_RegWrite(idex_RegWrite),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .exmem_RegWrite(exmem_RegWrite), .memwb_RegWrite(memwb_RegWrite),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (!rst_n || rs == 0) return 2'b00;
        if (exmem_RegWrite && exmem_rd == rs) return 2'b10;
        if (memwb_RegWrite && memwb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_load_use();
        return idex_MemRead && idex_rd != 0 &&
               (idex_rd == ifid_rs1 || (ifid_uses_rs2 && idex_rd == ifid_rs2));
    endfunction

    // Expected {pc_write, ifid_write, idex_write, idex_bubble, ifid_flush}
    function automatic logic [4:0] m_ctl();
        if (!rst_n)       return 5'b00110;
        if (mem_busy)     return 5'b00000;
        if (branch_taken) return 5'b11111;
        if (m_load_use()) return 5'b00110;
        return 5'b11100;
    endfunction

    // One cycle: check combinational outputs, clock, advance model, check registers.
    task automatic step(input string tag);
        logic [4:0] e;
        #1;
        e = m_ctl();
        check({tag, ":ctl"}, 32'({pc_write, ifid_write, idex_write, idex_bubble, ifid_flush}), 32'(e));
        check({tag, ":fwd_a"}, 32'(forward_a), 32'(m_fwd(idex_rs1)));
        check({tag, ":fwd_b"}, 32'(forward_b), 32'(m_fwd(idex_rs2)));
        @(posedge clk);
        if (!rst_n) begin
            m_stall = 0; m_flush = 0; m_wait = 0;
        end else begin
            if (!e[4]) m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            if (e[0])  m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
            m_wait = mem_busy;
        end
        #1;
        check({tag, ":stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
        check({tag, ":flush_cnt"}, 32'(flush_cnt), 32'(m_flush));
        check({tag, ":state"}, 32'(dut.state_q), m_wait ? 32'(ST_MEM_WAIT) : 32'(ST_RUN));
    endtask

    task automatic idle();
        rst_n = 1; idex_MemRead = 0; idex_RegWrite = 0;
        idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0;
        ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs2 = 0;
        exmem_RegWrite = 0; memwb_RegWrite = 0; exmem_rd = 0; memwb_rd = 0;
        branch_taken = 0; mem_busy = 0;
    endtask

    initial begin
        logic [15:0] saved_stall;
        idle();
        @(posedge clk); #1;

        // Reset values
        rst_n = 0;
        #1;
        check("rst_pc_write", 32'(pc_write), 0);
        check("rst_idex_write", 32'(idex_write), 1);
        check("rst_bubble", 32'(idex_bubble), 1);
        step("rst");
        check("rst_stall_zero", 32'(stall_cnt), 0);
        check("rst_flush_zero", 32'(flush_cnt), 0);
        rst_n = 1;

        // Load-use stall then release
        idex_MemRead = 1; idex_rd = 5; ifid_rs1 = 5;
        #1;
        check("lu_pc_write", 32'(pc_write), 0);
        check("lu_bubble", 32'(idex_bubble), 1);
        step("lu");
        check("lu_stall_cnt", 32'(stall_cnt), 1);
        idex_MemRead = 0;
        #1;
        check("lu_release_pc_write", 32'(pc_write), 1);
        step("lu_release");

        // Double forwarding
        idle();
        exmem_rd = 7; memwb_rd = 7; idex_rs1 = 7; exmem_RegWrite = 1; memwb_RegWrite = 1;
        #1; check("fwd_both", 32'(forward_a), 32'h2);
        step("fwd_both");
        exmem_RegWrite = 0;
        #1; check("fwd_memwb", 32'(forward_a), 32'h1);
        step("fwd_memwb");
        exmem_RegWrite = 1; idex_rs1 = 0; exmem_rd = 0; memwb_rd = 0;
        #1; check("fwd_x0", 32'(forward_a), 32'h0);
        step("fwd_x0");

        // Memory wait for 3 cycles
        idle();
        saved_stall = stall_cnt;
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1; check("mw_enables", 32'({pc_write, ifid_write, idex_write}), 0);
            step("mw");
        end
        check("mw_stall_plus3", 32'(stall_cnt), 32'(saved_stall) + 3);
        mem_busy = 0;
        step("mw_exit");
        check("mw_back_run", 32'(dut.state_q), 32'(ST_RUN));

        // Branch with simultaneous load-use
        saved_stall = stall_cnt;
        branch_taken = 1; idex_MemRead = 1; idex_rd = 5; ifid_rs1 = 5;
        #1;
        check("br_flush", 32'(ifid_flush), 1);
        check("br_pc_write", 32'(pc_write), 1);
        step("br");
        check("br_flush_cnt", 32'(flush_cnt), 1);
        check("br_stall_same", 32'(stall_cnt), 32'(saved_stall));

        // Reset during MEM_WAIT
        idle();
        mem_busy = 1;
        step("rw_enter");
        step("rw_hold");
        rst_n = 0;
        step("rw_reset");
        check("rw_state_run", 32'(dut.state_q), 32'(ST_RUN));
        check("rw_stall_zero", 32'(stall_cnt), 0);
        rst_n = 1; mem_busy = 0;
        #1; check("rw_pc_write", 32'(pc_write), 1);
        step("rw_release");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst_n          = ($urandom_range(0, 29) != 0);
            idex_MemRead   = 1'($urandom);
            idex_RegWrite  = 1'($urandom);
            idex_rs1       = 5'($urandom_range(0, 7));
            idex_rs2       = 5'($urandom_range(0, 7));
            idex_rd        = 5'($urandom_range(0, 7));
            ifid_rs1       = 5'($urandom_range(0, 7));
            ifid_rs2       = 5'($urandom_range(0, 7));
            ifid_uses_rs2  = 1'($urandom);
            exmem_RegWrite = 1'($urandom);
            memwb_RegWrite = 1'($urandom);
            exmem_rd       = 5'($urandom_range(0, 7));
            memwb_rd       = 5'($urandom_range(0, 7));
            branch_taken   = ($urandom_range(0, 5) == 0);
            mem_busy       = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        // Saturation: 16'hFFFE stalls, then 3 more
        idle();
        rst_n = 0;
        step("sat_rst");
        rst_n = 1; mem_busy = 1;
        for (int i = 0; i < 65534; i++) step("sat_fill");
        check("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        for (int i = 0; i < 3; i++) step("sat_more");
        check("sat_ffff", 32'(stall_cnt), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
